// File: rtl/softmax_pkg.sv
// Shared types and helpers for the three-pass softmax sequencer.
package softmax_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MAX      = 3'd1,
    S_MAX_DRN  = 3'd2,
    S_SUM      = 3'd3,
    S_SUM_DRN  = 3'd4,
    S_NORM     = 3'd5,
    S_NORM_DRN = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    PASS_NONE = 2'd0,
    PASS_MAX  = 2'd1,
    PASS_SUM  = 2'd2,
    PASS_NORM = 2'd3
  } pass_t;

  localparam int MASK_W = 32;

  // Low-order lane mask; a lane count of zero means every lane is valid.
  function automatic logic [MASK_W-1:0] lane_mask(input logic [MASK_W-1:0] lanes, input int num);
    logic [MASK_W-1:0] m;
    logic [MASK_W-1:0] eff;
    eff = (lanes == 32'd0) ? 32'(num) : lanes;
    m = {MASK_W{1'b0}};
    for (int i = 0; i < MASK_W; i++) begin
      m[i] = ($unsigned(i) < eff);
    end
    return m;
  endfunction

endpackage

// File: rtl/sm_delay_line.sv
// Shift-register delay with synchronous flush; zero depth is a plain wire.
module sm_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_s;
      assign unused_s = &{1'b0, clk, reset_n, flush};
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_r [DEPTH];

      // Shift chain, cleared by reset or flush
      always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= {WIDTH{1'b0}};
          end
        end else begin
          stage_r[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign dout = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/softmax_seq.sv
// Three-pass softmax sequencer: reads the buffer three times and drives
// latency-matched strobes for the max, sum/ln and normalise datapath stages.
module softmax_seq
  import softmax_pkg::*;
#(
  parameter int NUM      = 2,
  parameter int ADDRSIZE = 16,
  parameter int MEM_LAT  = 1,
  parameter int MAX_LAT  = 1,
  parameter int EXP_LAT  = 2,
  parameter int ADD_LAT  = 2,
  parameter int LOG_LAT  = 1,
  parameter int NORM_LAT = 4,
  localparam int LW      = $clog2(NUM + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDRSIZE-1:0] start_addr,
  input  logic [ADDRSIZE-1:0] end_addr,
  input  logic [LW-1:0]       last_lanes,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                rd_en,
  output logic [ADDRSIZE-1:0] rd_addr,
  output logic [NUM-1:0]      rd_mask,
  output logic                max_clr,
  output logic                max_en,
  output logic                acc_clr,
  output logic                sub_en,
  output logic                acc_en,
  output logic [NUM-1:0]      acc_mask,
  output logic                log_en,
  output logic                out_valid,
  output logic [ADDRSIZE-1:0] out_addr,
  output logic [NUM-1:0]      out_mask
);

  localparam int D1 = MEM_LAT + MAX_LAT;
  localparam int D2 = MEM_LAT + EXP_LAT + ADD_LAT + LOG_LAT;
  localparam int D3 = MEM_LAT + NORM_LAT;
  localparam int OW = 1 + ADDRSIZE + NUM;

  state_t              state_r, state_s;
  pass_t               pass_r, pass_s;
  logic [ADDRSIZE-1:0] base_addr_r, last_addr_r, cur_addr_r, cur_addr_s;
  logic [NUM-1:0]      last_mask_r, rd_mask_r, rd_mask_s;
  logic [31:0]         cnt_r, cnt_s;
  logic                accept_s, reject_s, rd_en_s, kill_s;
  logic                busy_r, done_r, err_r, rd_en_r, max_clr_r, acc_clr_r, log_en_r;
  logic [ADDRSIZE-1:0] rd_addr_r;
  logic [MASK_W-1:0]   lane_ext_s;
  logic                unused_s;

  assign lane_ext_s = lane_mask(MASK_W'(last_lanes), NUM);
  assign unused_s   = &{1'b0, lane_ext_s[MASK_W-1:NUM]};
  assign kill_s     = abort && (state_r != S_IDLE);

  // Next state, read address walk and drain counter
  always_comb begin
    state_s    = state_r;
    cur_addr_s = cur_addr_r;
    cnt_s      = cnt_r;
    accept_s   = 1'b0;
    reject_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start && !abort) begin
          if (end_addr > start_addr) begin
            accept_s   = 1'b1;
            state_s    = S_MAX;
            cur_addr_s = start_addr;
          end else begin
            reject_s = 1'b1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_MAX, S_SUM, S_NORM: begin
        if (cur_addr_r == last_addr_r) begin
          cur_addr_s = base_addr_r;
          if (state_r == S_MAX) begin
            state_s = S_MAX_DRN;
            cnt_s   = 32'(D1);
          end else if (state_r == S_SUM) begin
            state_s = S_SUM_DRN;
            cnt_s   = 32'(D2);
          end else begin
            state_s = S_NORM_DRN;
            cnt_s   = 32'(D3);
          end
        end else begin
          cur_addr_s = cur_addr_r + ADDRSIZE'(1);
        end
      end
      S_MAX_DRN, S_SUM_DRN, S_NORM_DRN: begin
        // A zero-length drain still occupies one cycle
        if (cnt_r <= 32'd1) begin
          cnt_s = 32'd0;
          if (state_r == S_MAX_DRN) begin
            state_s = S_SUM;
          end else if (state_r == S_SUM_DRN) begin
            state_s = S_NORM;
          end else begin
            state_s = S_DONE;
          end
        end else begin
          cnt_s = cnt_r - 32'd1;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Read strobe, pass tag and lane mask for the current state
  always_comb begin
    rd_en_s = 1'b0;
    pass_s  = PASS_NONE;
    case (state_r)
      S_MAX: begin
        rd_en_s = 1'b1;
        pass_s  = PASS_MAX;
      end
      S_SUM: begin
        rd_en_s = 1'b1;
        pass_s  = PASS_SUM;
      end
      S_NORM: begin
        rd_en_s = 1'b1;
        pass_s  = PASS_NORM;
      end
      default: begin
        rd_en_s = 1'b0;
        pass_s  = PASS_NONE;
      end
    endcase
    if (!rd_en_s) begin
      rd_mask_s = {NUM{1'b0}};
    end else if (cur_addr_r == last_addr_r) begin
      rd_mask_s = last_mask_r;
    end else begin
      rd_mask_s = {NUM{1'b1}};
    end
  end

  // State, job registers and registered control outputs
  always_ff @(posedge clk) begin
    if (!reset_n || kill_s) begin
      state_r     <= S_IDLE;
      pass_r      <= PASS_NONE;
      base_addr_r <= {ADDRSIZE{1'b0}};
      last_addr_r <= {ADDRSIZE{1'b0}};
      cur_addr_r  <= {ADDRSIZE{1'b0}};
      last_mask_r <= {NUM{1'b0}};
      cnt_r       <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= {ADDRSIZE{1'b0}};
      rd_mask_r   <= {NUM{1'b0}};
      max_clr_r   <= 1'b0;
      acc_clr_r   <= 1'b0;
      log_en_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      pass_r     <= pass_s;
      cur_addr_r <= cur_addr_s;
      cnt_r      <= cnt_s;
      if (accept_s) begin
        base_addr_r <= start_addr;
        last_addr_r <= end_addr - ADDRSIZE'(1);
        last_mask_r <= lane_ext_s[NUM-1:0];
      end
      busy_r    <= (state_r != S_IDLE) || accept_s;
      done_r    <= (state_r == S_DONE);
      err_r     <= reject_s;
      rd_en_r   <= rd_en_s;
      rd_addr_r <= rd_en_s ? cur_addr_r : {ADDRSIZE{1'b0}};
      rd_mask_r <= rd_mask_s;
      max_clr_r <= accept_s;
      acc_clr_r <= accept_s;
      log_en_r  <= (state_r == S_SUM_DRN) && (cnt_r == 32'(LOG_LAT));
    end
  end

  logic            p1_in_s;
  logic [NUM:0]    p2_in_s, p2_out_s, acc_out_s;
  logic [OW-1:0]   p3_in_s, p3_out_s;

  assign p1_in_s = rd_en_r && (pass_r == PASS_MAX);
  assign p2_in_s = (rd_en_r && (pass_r == PASS_SUM)) ? {1'b1, rd_mask_r} : {(NUM+1){1'b0}};
  assign p3_in_s = (rd_en_r && (pass_r == PASS_NORM)) ? {1'b1, rd_addr_r, rd_mask_r} : {OW{1'b0}};

  sm_delay_line #(.DEPTH(MEM_LAT), .WIDTH(1)) u_dl_max (
    .clk(clk), .reset_n(reset_n), .flush(kill_s), .din(p1_in_s), .dout(max_en)
  );

  sm_delay_line #(.DEPTH(MEM_LAT), .WIDTH(NUM + 1)) u_dl_sub (
    .clk(clk), .reset_n(reset_n), .flush(kill_s), .din(p2_in_s), .dout(p2_out_s)
  );

  sm_delay_line #(.DEPTH(EXP_LAT), .WIDTH(NUM + 1)) u_dl_acc (
    .clk(clk), .reset_n(reset_n), .flush(kill_s), .din(p2_out_s), .dout(acc_out_s)
  );

  sm_delay_line #(.DEPTH(MEM_LAT + NORM_LAT), .WIDTH(OW)) u_dl_out (
    .clk(clk), .reset_n(reset_n), .flush(kill_s), .din(p3_in_s), .dout(p3_out_s)
  );

  assign sub_en    = p2_out_s[NUM];
  assign acc_en    = acc_out_s[NUM];
  assign acc_mask  = acc_out_s[NUM-1:0];
  assign out_valid = p3_out_s[OW-1];
  assign out_addr  = p3_out_s[NUM +: ADDRSIZE];
  assign out_mask  = p3_out_s[NUM-1:0];

  assign busy    = busy_r;
  assign done    = done_r;
  assign err     = err_r;
  assign rd_en   = rd_en_r;
  assign rd_addr = rd_addr_r;
  assign rd_mask = rd_mask_r;
  assign max_clr = max_clr_r;
  assign acc_clr = acc_clr_r;
  assign log_en  = log_en_r;

endmodule

// File: tb/tb_softmax_seq.sv
// Directed bench for softmax_seq with NUM=4 and default latencies (D1=2, D2=6, D3=5).
module tb_softmax_seq;

  localparam int NUM = 4;
  localparam int AW  = 16;
  localparam int LW  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start, abort;
  logic [AW-1:0] start_addr, end_addr;
  logic [LW-1:0] last_lanes;
  logic          busy, done, err, rd_en, max_clr, max_en, acc_clr, sub_en, acc_en, log_en, out_valid;
  logic [AW-1:0] rd_addr, out_addr;
  logic [NUM-1:0] rd_mask, acc_mask, out_mask;

  softmax_seq #(.NUM(NUM), .ADDRSIZE(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .start_addr(start_addr), .end_addr(end_addr), .last_lanes(last_lanes),
    .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr(rd_addr), .rd_mask(rd_mask),
    .max_clr(max_clr), .max_en(max_en), .acc_clr(acc_clr), .sub_en(sub_en),
    .acc_en(acc_en), .acc_mask(acc_mask), .log_en(log_en),
    .out_valid(out_valid), .out_addr(out_addr), .out_mask(out_mask)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc, n_rd, n_max, n_sub, n_out, n_done, n_log, n_err, n_busy;
  int done_at, log_at, max_at, sub_at, acc_at, out_at;
  logic [AW-1:0]  rd_addr_q[$], out_addr_q[$];
  logic [NUM-1:0] rd_mask_q[$], acc_mask_q[$], out_mask_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    cyc = 0; n_rd = 0; n_max = 0; n_sub = 0; n_out = 0; n_done = 0; n_log = 0; n_err = 0; n_busy = 0;
    done_at = 0; log_at = 0; max_at = 0; sub_at = 0; acc_at = 0; out_at = 0;
    rd_addr_q.delete(); out_addr_q.delete(); rd_mask_q.delete(); acc_mask_q.delete(); out_mask_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rd_en) begin n_rd++; rd_addr_q.push_back(rd_addr); rd_mask_q.push_back(rd_mask); end
    if (max_en) begin n_max++; if (max_at == 0) max_at = cyc; end
    if (sub_en) begin n_sub++; if (sub_at == 0) sub_at = cyc; end
    if (acc_en) begin acc_mask_q.push_back(acc_mask); if (acc_at == 0) acc_at = cyc; end
    if (out_valid) begin
      n_out++; out_addr_q.push_back(out_addr); out_mask_q.push_back(out_mask);
      if (out_at == 0) out_at = cyc;
    end
    if (done) begin n_done++; done_at = cyc; end
    if (log_en) begin n_log++; log_at = cyc; end
    if (err) n_err++;
    if (busy) n_busy++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic launch(input logic [AW-1:0] sa, input logic [AW-1:0] ea, input logic [LW-1:0] ll);
    start_addr = sa; end_addr = ea; last_lanes = ll; start = 1'b1;
    clear_rec();
    tick();
    start = 1'b0;
  endtask

  task automatic chk_reads(input logic [AW-1:0] base, input int n, input logic [NUM-1:0] lastm);
    logic [AW-1:0] a;
    chk("rd_count", 64'(n_rd), 64'(3 * n));
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < n; i++) begin
        a = base + AW'(i);
        chk("rd_addr", 64'(rd_addr_q[p*n+i]), 64'(a));
        chk("rd_mask", 64'(rd_mask_q[p*n+i]), (i == n - 1) ? 64'(lastm) : 64'hF);
      end
    end
  endtask

  task automatic chk_outs(input logic [AW-1:0] base, input int n, input logic [NUM-1:0] lastm);
    logic [AW-1:0] a;
    chk("acc_count", 64'(acc_mask_q.size()), 64'(n));
    chk("out_count", 64'(n_out), 64'(n));
    for (int i = 0; i < n; i++) begin
      a = base + AW'(i);
      chk("acc_mask", 64'(acc_mask_q[i]), (i == n - 1) ? 64'(lastm) : 64'hF);
      chk("out_addr", 64'(out_addr_q[i]), 64'(a));
      chk("out_mask", 64'(out_mask_q[i]), (i == n - 1) ? 64'(lastm) : 64'hF);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, done, err, rd_en, rd_addr, rd_mask, max_clr, max_en, acc_clr,
                sub_en, acc_en, acc_mask, log_en, out_valid, out_addr, out_mask});
  endfunction

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    start_addr = 16'h0000; end_addr = 16'h0000; last_lanes = 3'd0;
    clear_rec();
    run(3);
    chk("reset_outs", all_outs(), 64'h0);
    reset_n = 1'b1;
    run(2);

    // Basic job: 4 words, full final word, done after 2+3*4+13 ticks
    launch(16'h0000, 16'h0004, 3'd0);
    chk("max_clr", 64'(max_clr), 64'h1);
    chk("acc_clr", 64'(acc_clr), 64'h1);
    chk("busy_start", 64'(busy), 64'h1);
    run(29);
    chk_reads(16'h0000, 4, 4'hF);
    chk_outs(16'h0000, 4, 4'hF);
    chk("max_en_cnt", 64'(n_max), 64'd4);
    chk("sub_en_cnt", 64'(n_sub), 64'd4);
    chk("done_cnt", 64'(n_done), 64'd1);
    chk("done_at", 64'(done_at), 64'd27);
    chk("log_cnt", 64'(n_log), 64'd1);
    chk("busy_cycles", 64'(n_busy), 64'd27);
    chk("busy_after", 64'(busy), 64'h0);

    // Partial final word with one valid lane
    launch(16'h0008, 16'h000B, 3'd1);
    run(27);
    chk_reads(16'h0008, 3, 4'h1);
    chk_outs(16'h0008, 3, 4'h1);
    chk("max_at", 64'(max_at), 64'd3);
    chk("sub_at", 64'(sub_at), 64'd8);
    chk("acc_at", 64'(acc_at), 64'd10);
    chk("log_at", 64'(log_at), 64'd15);
    chk("out_at", 64'(out_at), 64'd21);
    chk("done_at2", 64'(done_at), 64'd24);
    chk("busy_cycles2", 64'(n_busy), 64'd24);

    // Empty range is rejected
    launch(16'h0005, 16'h0005, 3'd0);
    chk("err_pulse", 64'(err), 64'h1);
    chk("err_busy", 64'(busy), 64'h0);
    run(5);
    chk("err_cnt", 64'(n_err), 64'd1);
    chk("err_rd", 64'(n_rd), 64'd0);
    chk("err_done", 64'(n_done), 64'd0);
    chk("err_busy_cnt", 64'(n_busy), 64'd0);

    // Abort in IDLE beats a simultaneous start
    abort = 1'b1;
    launch(16'h0000, 16'h0004, 3'd0);
    abort = 1'b0;
    chk("idle_abort_busy", 64'(busy), 64'h0);
    chk("idle_abort_clr", 64'(max_clr), 64'h0);
    run(3);
    chk("idle_abort_rd", 64'(n_rd), 64'd0);

    // Abort during SUM_DRN
    launch(16'h0000, 16'h0002, 3'd0);
    run(7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_rd", 64'(rd_en), 64'h0);
    run(30);
    chk("abort_out", 64'(n_out), 64'd0);
    chk("abort_done", 64'(n_done), 64'd0);
    chk("abort_log", 64'(n_log), 64'd0);
    launch(16'h0000, 16'h0002, 3'd0);
    run(25);
    chk_reads(16'h0000, 2, 4'hF);
    chk_outs(16'h0000, 2, 4'hF);
    chk("reabort_done_cnt", 64'(n_done), 64'd1);
    chk("reabort_done_at", 64'(done_at), 64'd21);

    // Start pulse during NORM is ignored
    launch(16'h0000, 16'h0004, 3'd0);
    run(17);
    start = 1'b1;
    tick();
    start = 1'b0;
    run(20);
    chk("busy_start_done", 64'(n_done), 64'd1);
    chk("busy_start_at", 64'(done_at), 64'd27);
    chk("busy_start_rd", 64'(n_rd), 64'd12);
    chk("busy_start_err", 64'(n_err), 64'd0);

    // Reset mid-NORM zeroes every output
    launch(16'h0008, 16'h000B, 3'd0);
    run(15);
    chk("norm_rd_en", 64'(rd_en), 64'h1);
    reset_n = 1'b0;
    tick();
    chk("midreset_outs", all_outs(), 64'h0);
    reset_n = 1'b1;
    run(10);
    chk("midreset_quiet", all_outs(), 64'h0);

    // Top of address space: no wrap
    launch(16'hFFFD, 16'hFFFF, 3'd0);
    run(24);
    chk_reads(16'hFFFD, 2, 4'hF);
    chk_outs(16'hFFFD, 2, 4'hF);
    chk("top_done_at", 64'(done_at), 64'd21);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
